// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the ADC capture block.
package adc_cap_pkg;

  // Capture controller states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } cap_state_t;

  // A requested length of 0, or one beyond the buffer, becomes a full buffer
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input int unsigned addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    if ((len == 32'd0) || (len > depth)) begin
      return depth;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/adc_capture_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Written so synthesis maps it onto a block RAM (read-before-write on collision).
module sdp_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; the array itself is never reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; a same-cycle write is not visible until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// ADC capture: edge-detects the divided sample clock, latches the ADC word,
// optionally waits for a level crossing, then stores one frame in a buffer
// that the MCU reads by address.
module adc_capture
  import adc_cap_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_clk_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              trig_en_i,
  input  logic              trig_rise_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic [ADDR_W:0]   frame_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   wr_count_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  cap_state_t        state_q, state_d;
  logic              adc_clk_q;
  logic              stb_s;
  logic [DATA_W-1:0] sample_q;
  logic              sample_v_q;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              trig_en_q, trig_en_d;
  logic              trig_rise_q, trig_rise_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  len_clamp_s;
  logic [LEN_W-1:0]  wr_count_q, wr_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cross_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;

  assign stb_s       = adc_clk_i & ~adc_clk_q;
  assign len_clamp_s = LEN_W'(clamp_len(32'(frame_len_i), ADDR_W));
  assign cross_s     = trig_rise_q ? ((prev_q < level_q) && (sample_q >= level_q))
                                   : ((prev_q > level_q) && (sample_q <= level_q));

  // Edge-detect the sample clock and latch the ADC word on its rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_clk_q  <= 1'b0;
      sample_q   <= {DATA_W{1'b0}};
      sample_v_q <= 1'b0;
    end else begin
      adc_clk_q  <= adc_clk_i;
      sample_v_q <= stb_s;
      if (stb_s) begin
        sample_q <= adc_data_i;
      end
    end
  end

  // Next-state, buffer write and status decode for the capture controller
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    trig_en_d   = trig_en_q;
    trig_rise_d = trig_rise_q;
    level_d     = level_q;
    len_d       = len_q;
    wr_count_d  = wr_count_q;
    we_s        = 1'b0;
    waddr_s     = wr_count_q[ADDR_W-1:0];

    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            trig_en_d   = trig_en_i;
            trig_rise_d = trig_rise_i;
            level_d     = trig_level_i;
            len_d       = len_clamp_s;
            wr_count_d  = {LEN_W{1'b0}};
            have_prev_d = 1'b0;
            state_d     = trig_en_i ? WAIT_TRIG : CAPTURE;
          end else begin
            state_d = state_q;
          end
        end
        WAIT_TRIG: begin
          if (sample_v_q) begin
            // The first sample after arming only seeds the comparison
            prev_d      = sample_q;
            have_prev_d = 1'b1;
            if (have_prev_q && cross_s) begin
              we_s       = 1'b1;
              waddr_s    = {ADDR_W{1'b0}};
              wr_count_d = LEN_W'(1);
              state_d    = (len_q == LEN_W'(1)) ? DONE : CAPTURE;
            end else begin
              state_d = WAIT_TRIG;
            end
          end else begin
            state_d = WAIT_TRIG;
          end
        end
        CAPTURE: begin
          if (sample_v_q) begin
            we_s       = 1'b1;
            wr_count_d = wr_count_q + LEN_W'(1);
            if (wr_count_d == len_q) begin
              state_d = DONE;
            end else begin
              state_d = CAPTURE;
            end
          end else begin
            state_d = CAPTURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == WAIT_TRIG) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  // Controller state, frame configuration, counters and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= {DATA_W{1'b0}};
      have_prev_q <= 1'b0;
      trig_en_q   <= 1'b0;
      trig_rise_q <= 1'b0;
      level_q     <= {DATA_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      wr_count_q  <= {LEN_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      trig_en_q   <= trig_en_d;
      trig_rise_q <= trig_rise_d;
      level_q     <= level_d;
      len_q       <= len_d;
      wr_count_q  <= wr_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (sample_q),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_data_o)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_count_o = wr_count_q;

endmodule
